pc_sequencer: RTL

//  Program-counter controller for the MIPS core. Owns the PC register and

---
 rtl/pc_sequencer.sv | 95 +++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC, fetches each instruction over the
// imem req/ack handshake, holds it for the core and picks the next PC on retire.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        retire,
  input  logic        br_taken,
  input  logic        jump,
  input  logic        jump_reg,
  input  logic [31:0] br_offset,
  input  logic [31:0] jr_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        exc_misalign
);

  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] EXEC  = 2'd2;

  logic [1:0]  state;
  logic [31:0] br_target;
  logic [31:0] jump_target;
  logic [31:0] next_pc;
  logic        jr_misaligned;
  logic        retire_now;

  assign pc_plus4    = pc + 32'd4;
  assign br_target   = pc_plus4 + (br_offset << 2);
  assign jump_target = {pc_plus4[31:28], instr[25:0], 2'b00};

  assign jr_misaligned = (jr_target[1:0] != 2'b00);
  assign retire_now    = (state == EXEC) && retire;

  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;

  // jr/jalr outranks j/jal, which outranks a taken branch
  always_comb begin
    next_pc = pc_plus4;
    if (jump_reg) begin
      next_pc = jr_misaligned ? EXC_VECTOR : jr_target;
    end else if (jump) begin
      next_pc = jump_target;
    end else if (br_taken) begin
      next_pc = br_target;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= BOOT;
      pc           <= RESET_PC;
      instr        <= 32'd0;
      instr_valid  <= 1'b0;
      exc_misalign <= 1'b0;
    end else begin
      exc_misalign <= 1'b0;
      case (state)
        BOOT: begin
          state <= FETCH;
        end
        FETCH: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            state       <= EXEC;
          end
        end
        EXEC: begin
          if (retire_now) begin
            pc           <= next_pc;
            instr_valid  <= 1'b0;
            exc_misalign <= jump_reg && jr_misaligned;
            state        <= FETCH;
          end
        end
        default: begin
          instr_valid <= 1'b0;
          state       <= BOOT;
        end
      endcase
    end
  end

endmodule
